dac_axil_mc_regbank: RTL and testbench
======================================

// Module: dac_axil_mc_regbank
// PURPOSE
//  Multi-channel AXI4-Lite register bank for the DAC path. Successor of the fixed 4-register DAC slave.
//  Channel count and sample width are parameters. Holds per-channel shadow registers.
//  Transfers all shadows to an active bank on a load event (LDAC semantics).
//  Presents the active bank to the downstream DAC serializer over a valid/ready handshake.
// PARAMETERS
//  NUM_CH   4   number of DAC channels, 1..14
//  DATA_W   16  sample width per channel, 1..32
//  ADDR_W   6   AXI address width; (NUM_CH+2)*4 <= 2**ADDR_W
// PORTS
//  ACLK           in   1               clock
//  ARESETN        in   1               asynchronous active-low reset
//  S_AXI_AWADDR   in   ADDR_W          write address
//  S_AXI_AWVALID  in   1               write address valid
//  S_AXI_AWREADY  out  1               write address ready
//  S_AXI_WDATA    in   32              write data
//  S_AXI_WSTRB    in   4               write byte strobes
//  S_AXI_WVALID   in   1               write data valid
//  S_AXI_WREADY   out  1               write data ready
//  S_AXI_BRESP    out  2               write response: 00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1               write response valid
//  S_AXI_BREADY   in   1               write response ready
//  S_AXI_ARADDR   in   ADDR_W          read address
//  S_AXI_ARVALID  in   1               read address valid
//  S_AXI_ARREADY  out  1               read address ready
//  S_AXI_RDATA    out  32              read data
//  S_AXI_RRESP    out  2               read response
//  S_AXI_RVALID   out  1               read data valid
//  S_AXI_RREADY   in   1               read data ready
//  ldac_n         in   1               external async load pin, active-low
//  dac_data       out  NUM_CH*DATA_W   active bank; ch0 in LSBs
//  dac_valid      out  1               active bank ready for transfer
//  dac_ready      in   1               serializer accepts bank
// BEHAVIOUR
//  Reset: all AXI outputs, RDATA/BRESP/RRESP, CTRL, shadows, active bank, dac_valid, pending and UPD_CNT = 0.
//  Map (word addresses, ADDR[1:0] ignored):
//   0x00  CTRL: b0 EN, b1 AUTO. b2 LOAD: write 1 pulses; reads 0.
//   0x04  STATUS (RO): b0 dac_valid, b1 pending, b15:8 UPD_CNT.
//   0x08+4*n  shadow of channel n.
//  Channel register bits: [DATA_W-1:0] stored; upper bits ignored on write, read as 0.
//  Writes:
//   - AWREADY/WREADY are high when the address/data slot is empty and BVALID=0.
//   - AW and W may arrive in either order or together; each is latched separately.
//   - Register update occurs the cycle after both are held. WSTRB is honoured per byte.
//   - BVALID rises in the same cycle and is held until BREADY.
//   - Unmapped address or a write to STATUS: no state change, BRESP=SLVERR.
//  Reads:
//   - ARREADY is high when RVALID=0. RVALID rises 1 cycle after the AR handshake.
//   - RDATA/RRESP are held stable until RREADY. Unmapped address: RDATA=0, RRESP=SLVERR.
//  ldac_n: 2-FF synchronized. A synchronized falling edge is a load request.
//  Load request sources: CTRL.LOAD write; any channel write when AUTO=1; ldac_n falling edge.
//   All sources are ignored when EN=0.
//   Simultaneous sources in one cycle count as one request.
//  On request:
//   - dac_valid=0, or dac_valid&dac_ready in the same cycle: active <= shadow and dac_valid=1 next cycle.
//     The shadow includes a channel write committed in that same cycle. UPD_CNT increments and wraps 255->0.
//   - dac_valid=1 and dac_ready=0: pending <= 1; active is unchanged; extra requests merge.
//  Handshake (dac_valid&dac_ready) with pending=1:
//   - active <= current shadow; dac_valid stays 1; pending <= 0; UPD_CNT increments.
//  Handshake with pending=0: dac_valid <= 0.
//  dac_data is stable whenever dac_valid=1 && !dac_ready.
//  Clearing EN does not drop an asserted dac_valid; a pending load still completes.
//  Reset mid-transfer: dac_valid drops immediately; the pending load is lost.
// TESTING
//  T1 reset: ARESETN low mid-write -> all outputs 0; reads of CH0..CH3 return 0 after release.
//  T2 regs: write 0x1,0x2,0x3,0x4 to 0x08..0x14, W before AW on one write -> readback equal;
//     write 0xFFFF_ABCD with DATA_W=16 -> reads 0x0000_ABCD; WSTRB=0001 byte merge.
//  T3 load: EN=1, shadows 0x111/0x222, write CTRL=0x5 -> dac_valid=1 next cycle;
//     dac_data={0x222,0x111}; STATUS=0x0101.
//  T4 backpressure: dac_ready=0, LOAD, rewrite CH0=0x999, LOAD -> pending=1, dac_data unchanged;
//     dac_ready pulse -> dac_data CH0=0x999, valid stays, then drops on second handshake.
//  T5 AUTO+pin: CTRL=0x3, write CH1 -> load; ldac_n low pulse 2 cycles -> one load;
//     EN=0 then ldac_n pulse -> UPD_CNT unchanged.
//  T6 errors: write 0x04 and 0x3C -> SLVERR, no state change; read 0x3C -> RDATA=0, SLVERR;
//     BREADY/RREADY held low 10 cycles -> responses stable.

Source files
------------

// File: rtl/dac_axil_mc_regbank.sv
// AXI4-Lite register bank for a multi-channel DAC: per-channel shadow registers,
// LDAC-style transfer into an active bank, and a valid/ready hand-off to the serializer.
module dac_axil_mc_regbank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic                     ldac_n,
  output logic [NUM_CH*DATA_W-1:0] dac_data,
  output logic                     dac_valid,
  input  logic                     dac_ready
);
  localparam int IW = ADDR_W - 2;

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  logic                          rdy_en, aw_full, w_full;
  logic [IW-1:0]                 aw_idx, ar_idx;
  logic [31:0]                   w_data;
  logic [3:0]                    w_strb;
  logic                          en, auto_ld, pending;
  logic [7:0]                    upd_cnt;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow, shadow_nxt, active;
  logic                          en_nxt, auto_nxt, wr_load, wr_ch, wr_ok;
  logic [31:0]                   old_val, new_val, rd_val;
  logic                          rd_ok;
  logic [2:0]                    ldac_sync;
  logic                          ldac_fall, ld_req, hs, wr_go;
  logic                          aw_hs, w_hs, ar_hs;
  logic                          unused;

  // rdy_en keeps every ready low while reset is asserted
  assign S_AXI_AWREADY = rdy_en & ~aw_full & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = rdy_en & ~w_full & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = rdy_en & ~S_AXI_RVALID;
  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_go  = aw_full & w_full;
  assign ar_idx = S_AXI_ARADDR[ADDR_W-1:2];
  assign hs     = dac_valid & dac_ready;
  assign dac_data = active;
  assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], new_val};

  always_comb begin
    shadow_nxt = shadow;
    en_nxt     = en;
    auto_nxt   = auto_ld;
    wr_load    = 1'b0;
    wr_ch      = 1'b0;
    wr_ok      = 1'b0;
    old_val    = '0;
    new_val    = '0;
    if (wr_go) begin
      if (aw_idx == '0) begin
        old_val  = {30'd0, auto_ld, en};
        new_val  = strb_merge(old_val, w_data, w_strb);
        en_nxt   = new_val[0];
        auto_nxt = new_val[1];
        wr_load  = new_val[2];
        wr_ok    = 1'b1;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (aw_idx == IW'(n + 2)) begin
          old_val               = '0;
          old_val[DATA_W-1:0]   = shadow[n];
          new_val               = strb_merge(old_val, w_data, w_strb);
          shadow_nxt[n]         = new_val[DATA_W-1:0];
          wr_ch                 = 1'b1;
          wr_ok                 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    if (ar_idx == '0) begin
      rd_val = {30'd0, auto_ld, en};
      rd_ok  = 1'b1;
    end
    if (ar_idx == IW'(1)) begin
      rd_val = {16'd0, upd_cnt, 6'd0, pending, dac_valid};
      rd_ok  = 1'b1;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (ar_idx == IW'(n + 2)) begin
        rd_val[DATA_W-1:0] = shadow[n];
        rd_ok              = 1'b1;
      end
    end
  end

  // A CTRL write that sets EN and LOAD together is honoured in the same beat
  assign ldac_fall = ldac_sync[2] & ~ldac_sync[1];
  assign ld_req    = en_nxt & (wr_load | (auto_ld & wr_ch) | ldac_fall);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en       <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= 2'b00;
      en           <= 1'b0;
      auto_ld      <= 1'b0;
      shadow       <= '0;
      ldac_sync    <= '1;
    end else begin
      rdy_en    <= 1'b1;
      ldac_sync <= {ldac_sync[1:0], ldac_n};
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (wr_go) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      en      <= en_nxt;
      auto_ld <= auto_nxt;
      shadow  <= shadow_nxt;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
        S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Active bank: a request while the bank is held becomes pending and merges
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      active    <= '0;
      dac_valid <= 1'b0;
      pending   <= 1'b0;
      upd_cnt   <= '0;
    end else if (ld_req && (!dac_valid || hs)) begin
      active    <= shadow_nxt;
      dac_valid <= 1'b1;
      pending   <= 1'b0;
      upd_cnt   <= upd_cnt + 8'd1;
    end else if (ld_req) begin
      pending <= 1'b1;
    end else if (hs && pending) begin
      active  <= shadow_nxt;
      pending <= 1'b0;
      upd_cnt <= upd_cnt + 8'd1;
    end else if (hs) begin
      dac_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dac_axil_mc_regbank.sv
// Directed bench for dac_axil_mc_regbank: AXI responses are checked by a scoreboard
// monitor, DAC-side outputs by direct comparisons against hand-computed values.
module tb_dac_axil_mc_regbank;
  logic        ACLK = 0, ARESETN = 0;
  logic [5:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic        S_AXI_AWVALID = 0, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 0, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY = 1;
  logic        S_AXI_ARVALID = 0, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY = 1;
  logic        ldac_n = 1;
  logic [63:0] dac_data;
  logic        dac_valid, dac_ready = 0;

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10;

  dac_axil_mc_regbank #(.NUM_CH(4), .DATA_W(16), .ADDR_W(6)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ldac_n(ldac_n), .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t bq[$], rq[$];
  exp_t be, re;
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // Scoreboard monitor: a response is consumed on the edge after a negedge showing valid&ready
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          chk(be.nm, {62'd0, S_AXI_BRESP}, {62'd0, be.resp});
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          chk(re.nm, {30'd0, S_AXI_RRESP, S_AXI_RDATA}, {30'd0, re.resp, re.data});
        end
      end
    end
  end

  task automatic aw_w(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit w_first);
    int t;
    bit aw_go, w_go;
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_WSTRB   = s;
    S_AXI_WVALID  = 1;
    S_AXI_AWVALID = !w_first;
    t = 0;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 50) begin
      @(negedge ACLK);
      aw_go = S_AXI_AWVALID & S_AXI_AWREADY;
      w_go  = S_AXI_WVALID & S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) S_AXI_AWVALID = 0;
      if (w_go) begin
        S_AXI_WVALID = 0;
        if (w_first) S_AXI_AWVALID = 1;
      end
      t++;
    end
    if (t >= 50) begin
      timeout_fail("aw_w_timeout");
      S_AXI_AWVALID = 0;
      S_AXI_WVALID  = 0;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input string nm, input bit w_first = 0,
                    input int hold = 0);
    int t;
    bit stable;
    bq.push_back('{nm: nm, data: 32'd0, resp: er});
    S_AXI_BREADY = (hold == 0);
    aw_w(a, d, s, w_first);
    t = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) timeout_fail({nm, "_b_timeout"});
    if (hold > 0) begin
      stable = 1;
      repeat (hold) begin
        @(negedge ACLK);
        if (!S_AXI_BVALID || S_AXI_BRESP !== er) stable = 0;
      end
      chk({nm, "_b_hold"}, {63'd0, stable}, 64'd1);
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input string nm, input int hold = 0);
    int t;
    bit stable;
    rq.push_back('{nm: nm, data: ed, resp: er});
    S_AXI_RREADY  = (hold == 0);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1;
    t = 0;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) timeout_fail({nm, "_ar_timeout"});
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    t = 0;
    @(negedge ACLK);
    while (!S_AXI_RVALID && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) timeout_fail({nm, "_r_timeout"});
    if (hold > 0) begin
      stable = 1;
      repeat (hold) begin
        @(negedge ACLK);
        if (!S_AXI_RVALID || S_AXI_RDATA !== ed || S_AXI_RRESP !== er) stable = 0;
      end
      chk({nm, "_r_hold"}, {63'd0, stable}, 64'd1);
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1;
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic dac_pulse();
    dac_ready = 1;
    @(posedge ACLK); #1;
    dac_ready = 0;
  endtask

  task automatic ldac_pulse();
    ldac_n = 0;
    repeat (2) @(posedge ACLK);
    #1 ldac_n = 1;
    repeat (6) @(posedge ACLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, {63'd0, S_AXI_AWREADY}, 0);
    chk({tag, "_wready"},  {63'd0, S_AXI_WREADY}, 0);
    chk({tag, "_arready"}, {63'd0, S_AXI_ARREADY}, 0);
    chk({tag, "_bvalid"},  {63'd0, S_AXI_BVALID}, 0);
    chk({tag, "_rvalid"},  {63'd0, S_AXI_RVALID}, 0);
    chk({tag, "_resp"},    {60'd0, S_AXI_BRESP, S_AXI_RRESP}, 0);
    chk({tag, "_rdata"},   {32'd0, S_AXI_RDATA}, 0);
    chk({tag, "_dac_valid"}, {63'd0, dac_valid}, 0);
    chk({tag, "_dac_data"},  dac_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset, then reset asserted while a write is in flight
    repeat (3) @(posedge ACLK);
    #1 chk_all_zero("rst_init");
    ARESETN = 1;
    repeat (2) @(posedge ACLK);
    #1;
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge ACLK); #1;
    ARESETN = 0; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    #1 chk_all_zero("rst_mid");
    @(posedge ACLK); #1 ARESETN = 1;
    repeat (2) @(posedge ACLK);
    #1;
    rd(6'h08, 0, OK, "t1_ch0"); rd(6'h0C, 0, OK, "t1_ch1");
    rd(6'h10, 0, OK, "t1_ch2"); rd(6'h14, 0, OK, "t1_ch3");

    // T2: register write/readback, W before AW, width masking, byte strobes
    wr(6'h08, 32'h1, 4'hF, OK, "t2_w_ch0");
    wr(6'h0C, 32'h2, 4'hF, OK, "t2_w_ch1_wfirst", 1);
    wr(6'h10, 32'h3, 4'hF, OK, "t2_w_ch2");
    wr(6'h14, 32'h4, 4'hF, OK, "t2_w_ch3");
    rd(6'h08, 32'h1, OK, "t2_r_ch0"); rd(6'h0C, 32'h2, OK, "t2_r_ch1");
    rd(6'h10, 32'h3, OK, "t2_r_ch2"); rd(6'h14, 32'h4, OK, "t2_r_ch3");
    wr(6'h08, 32'hFFFF_ABCD, 4'hF, OK, "t2_w_wide");
    rd(6'h08, 32'h0000_ABCD, OK, "t2_r_wide");
    wr(6'h08, 32'h1234_5677, 4'b0001, OK, "t2_w_strb");
    rd(6'h08, 32'h0000_AB77, OK, "t2_r_strb");
    chk("t2_no_load", {63'd0, dac_valid}, 0);

    // T3: EN+LOAD transfers the shadows
    wr(6'h08, 32'h111, 4'hF, OK, "t3_w_ch0");
    wr(6'h0C, 32'h222, 4'hF, OK, "t3_w_ch1");
    wr(6'h00, 32'h5, 4'hF, OK, "t3_w_ctrl");
    chk("t3_valid", {63'd0, dac_valid}, 1);
    chk("t3_data", dac_data, 64'h0004_0003_0222_0111);
    rd(6'h04, 32'h0101, OK, "t3_status");
    rd(6'h00, 32'h1, OK, "t3_ctrl");

    // T4: backpressure, pending load, then two handshakes
    wr(6'h08, 32'h999, 4'hF, OK, "t4_w_ch0");
    wr(6'h00, 32'h5, 4'hF, OK, "t4_w_load");
    chk("t4_data_held", dac_data, 64'h0004_0003_0222_0111);
    rd(6'h04, 32'h0103, OK, "t4_status_pend");
    dac_pulse();
    chk("t4_valid_stays", {63'd0, dac_valid}, 1);
    chk("t4_data_new", dac_data, 64'h0004_0003_0222_0999);
    rd(6'h04, 32'h0201, OK, "t4_status_after");
    dac_pulse();
    chk("t4_valid_drop", {63'd0, dac_valid}, 0);
    rd(6'h04, 32'h0200, OK, "t4_status_idle");

    // T5: AUTO load on channel write, external pin, pin ignored when EN=0
    wr(6'h00, 32'h3, 4'hF, OK, "t5_w_ctrl");
    chk("t5_ctrl_no_load", {63'd0, dac_valid}, 0);
    wr(6'h0C, 32'h333, 4'hF, OK, "t5_w_ch1");
    chk("t5_auto_valid", {63'd0, dac_valid}, 1);
    chk("t5_auto_data", dac_data, 64'h0004_0003_0333_0999);
    dac_pulse();
    ldac_pulse();
    chk("t5_pin_valid", {63'd0, dac_valid}, 1);
    rd(6'h04, 32'h0401, OK, "t5_status_pin");
    dac_pulse();
    wr(6'h00, 32'h0, 4'hF, OK, "t5_w_dis");
    ldac_pulse();
    chk("t5_dis_valid", {63'd0, dac_valid}, 0);
    rd(6'h04, 32'h0400, OK, "t5_status_dis");

    // T6: error responses and held responses under BREADY/RREADY low
    wr(6'h04, 32'hFFFF_FFFF, 4'hF, SLV, "t6_w_status");
    rd(6'h04, 32'h0400, OK, "t6_status_same");
    wr(6'h3C, 32'h1234, 4'hF, SLV, "t6_w_unmapped", 0, 10);
    rd(6'h00, 32'h0, OK, "t6_ctrl_same");
    rd(6'h3C, 32'h0, SLV, "t6_r_unmapped");
    rd(6'h18, 32'h0, SLV, "t6_r_past_last_ch");
    rd(6'h08, 32'h999, OK, "t6_r_hold", 10);

    // T7: reset while a bank is held with a pending load
    wr(6'h00, 32'h5, 4'hF, OK, "t7_w_load1");
    wr(6'h00, 32'h5, 4'hF, OK, "t7_w_load2");
    chk("t7_valid", {63'd0, dac_valid}, 1);
    ARESETN = 0;
    #1;
    chk("t7_rst_valid", {63'd0, dac_valid}, 0);
    chk("t7_rst_data", dac_data, 0);
    @(posedge ACLK); #1 ARESETN = 1;
    repeat (2) @(posedge ACLK);
    #1;
    rd(6'h04, 32'h0, OK, "t7_status");
    rd(6'h08, 32'h0, OK, "t7_ch0");

    repeat (3) @(posedge ACLK);
    chk("b_queue_empty", 64'(bq.size()), 0);
    chk("r_queue_empty", 64'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
